// File: rtl/port_egress_buffer.sv
// port_egress_buffer
//   Per-port store-and-forward egress buffer. Takes the orchestrator's 9-bit
//   word stream (bit 8 = start-of-frame, no backpressure), keeps only complete
//   frames of at least MIN_FRAME_WORDS words, and replays committed frames as
//   a byte stream with valid/ready, start and last flags.
//
//   Optional feature macro: PORT_EGRESS_BUFFER_DROP_COUNT_EN
//     defined   -> frame_drop_count counts dropped frames (saturating)
//     undefined -> no counter is built, frame_drop_count reads 16'h0000
//
//   Ports
//     clock, reset                  rising-edge clock, async active-high reset
//     port_transmit_data[8:0]       input word, bit 8 = start-of-frame
//     port_transmit_data_valid      input word valid (no backpressure)
//     transmit_data[7:0]            output byte
//     transmit_data_valid           output byte valid
//     transmit_data_start           output byte is first of a frame
//     transmit_data_last            output byte is last of a frame
//     transmit_data_ready           transmitter accepts the output byte
//     buffer_level                  occupied entries, including uncommitted
//     frame_drop_count[15:0]        dropped frames, saturating
module port_egress_buffer #(
    parameter int unsigned DEPTH           = 64,
    parameter logic [15:0] GAP_LIMIT       = 16'h000F,
    parameter int unsigned MIN_FRAME_WORDS = 12
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [8:0]               port_transmit_data,
    input  logic                     port_transmit_data_valid,
    output logic [7:0]               transmit_data,
    output logic                     transmit_data_valid,
    output logic                     transmit_data_start,
    output logic                     transmit_data_last,
    input  logic                     transmit_data_ready,
    output logic [$clog2(DEPTH):0]   buffer_level,
    output logic [15:0]              frame_drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;
    typedef enum logic [1:0] {W_IDLE, W_FRAME, W_DISCARD} wr_state_t;

    localparam ptr_t DEPTH_PTR   = ptr_t'(DEPTH);
    localparam ptr_t MIN_LEN_PTR = ptr_t'(MIN_FRAME_WORDS);

    logic [8:0] mem [DEPTH];

    wr_state_t   state_q;
    ptr_t        write_pointer_q, commit_pointer_q, read_pointer_q;
    logic [15:0] gap_q;

    logic in_valid, in_sof;
    logic full, long_enough, gap_hit, base_full;
    ptr_t base_ptr, write_addr, read_next;
    logic mem_we, drop_event, load;
    logic [8:0] read_word, next_word;

    assign in_valid = port_transmit_data_valid;
    assign in_sof   = port_transmit_data[8];

    assign full        = (write_pointer_q - read_pointer_q) == DEPTH_PTR;
    assign long_enough = (write_pointer_q - commit_pointer_q) >= MIN_LEN_PTR;
    assign gap_hit     = gap_q == (GAP_LIMIT - 16'd1);

    // Write position after a start word closes the open frame: after the
    // commit, or at the rewound position if the frame was a runt.
    assign base_ptr  = long_enough ? write_pointer_q : commit_pointer_q;
    assign base_full = (base_ptr - read_pointer_q) == DEPTH_PTR;

    always_comb begin
        mem_we = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                W_IDLE:    mem_we = in_sof && !full;
                W_FRAME:   mem_we = in_sof ? !base_full : !full;
                W_DISCARD: mem_we = in_sof && !full;
                default:   mem_we = 1'b0;
            endcase
        end
    end

    assign write_addr = (state_q == W_FRAME && in_sof) ? base_ptr : write_pointer_q;

    // One frame is lost per cycle at most: a runt close and a full buffer
    // after that close cannot coincide, since the rewind frees space.
    always_comb begin
        drop_event = 1'b0;
        unique case (state_q)
            W_IDLE:    drop_event = in_valid && in_sof && full;
            W_FRAME:   drop_event = in_valid ? (in_sof ? (!long_enough || base_full) : full)
                                             : (gap_hit && !long_enough);
            W_DISCARD: drop_event = in_valid && in_sof && full;
            default:   drop_event = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (mem_we) mem[write_addr[AW-1:0]] <= port_transmit_data;
    end

    // Write FSM
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= W_IDLE;
            write_pointer_q  <= '0;
            commit_pointer_q <= '0;
            gap_q            <= '0;
        end else begin
            if (in_valid) gap_q <= '0;
            unique case (state_q)
                W_IDLE: begin
                    if (in_valid && in_sof) state_q <= mem_we ? W_FRAME : W_DISCARD;
                end
                W_FRAME: begin
                    if (in_valid) begin
                        if (in_sof) begin
                            if (long_enough) commit_pointer_q <= write_pointer_q;
                            if (!mem_we) begin
                                state_q         <= W_DISCARD;
                                write_pointer_q <= base_ptr;
                            end
                        end else if (!mem_we) begin
                            state_q         <= W_DISCARD;
                            write_pointer_q <= commit_pointer_q;
                        end
                    end else if (gap_hit) begin
                        gap_q   <= '0;
                        state_q <= W_IDLE;
                        if (long_enough) commit_pointer_q <= write_pointer_q;
                        else             write_pointer_q  <= commit_pointer_q;
                    end else begin
                        gap_q <= gap_q + 16'd1;
                    end
                end
                W_DISCARD: begin
                    if (in_valid) begin
                        if (mem_we) state_q <= W_FRAME;
                    end else if (gap_hit) begin
                        gap_q   <= '0;
                        state_q <= W_IDLE;
                    end else begin
                        gap_q <= gap_q + 16'd1;
                    end
                end
                default: state_q <= W_IDLE;
            endcase
            // Any accepted word advances from its write position; this
            // overrides the rewinds above only when a word is written.
            if (mem_we) write_pointer_q <= write_addr + ptr_t'(1);
        end
    end

    // Read side
    assign read_next = read_pointer_q + ptr_t'(1);
    assign read_word = mem[read_pointer_q[AW-1:0]];
    assign next_word = mem[read_next[AW-1:0]];
    assign load      = (read_pointer_q != commit_pointer_q)
                       && (!transmit_data_valid || transmit_data_ready);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_pointer_q      <= '0;
            transmit_data       <= '0;
            transmit_data_valid <= 1'b0;
            transmit_data_start <= 1'b0;
            transmit_data_last  <= 1'b0;
        end else if (load) begin
            read_pointer_q      <= read_next;
            transmit_data       <= read_word[7:0];
            transmit_data_valid <= 1'b1;
            transmit_data_start <= read_word[8];
            transmit_data_last  <= (read_next == commit_pointer_q)
                                   || (next_word[8] && read_next != write_pointer_q);
        end else if (transmit_data_ready) begin
            transmit_data_valid <= 1'b0;
        end
    end

    assign buffer_level = write_pointer_q - read_pointer_q;

`ifdef PORT_EGRESS_BUFFER_DROP_COUNT_EN
    logic [15:0] drop_count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_count_q <= '0;
        end else if (drop_event && drop_count_q != 16'hFFFF) begin
            drop_count_q <= drop_count_q + 16'd1;
        end
    end

    assign frame_drop_count = drop_count_q;
`else
    logic unused_drop_event;
    assign unused_drop_event = drop_event;
    assign frame_drop_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_port_egress_buffer.sv
// Directed bench for port_egress_buffer, built with DEPTH = 16 so the
// full-buffer discard path is reachable with a short frame.
module tb_port_egress_buffer;

    localparam int unsigned DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [8:0]  port_transmit_data;
    logic        port_transmit_data_valid;
    logic [7:0]  transmit_data;
    logic        transmit_data_valid;
    logic        transmit_data_start;
    logic        transmit_data_last;
    logic        transmit_data_ready;
    logic [4:0]  buffer_level;
    logic [15:0] frame_drop_count;

    int checks = 0;
    int errors = 0;
    int exp_drop = 0;

    // Transferred bytes as {start, last, data}
    logic [9:0] got [$];

    port_egress_buffer #(
        .DEPTH           (DEPTH),
        .GAP_LIMIT       (16'h000F),
        .MIN_FRAME_WORDS (12)
    ) dut (
        .clock                    (clock),
        .reset                    (reset),
        .port_transmit_data       (port_transmit_data),
        .port_transmit_data_valid (port_transmit_data_valid),
        .transmit_data            (transmit_data),
        .transmit_data_valid      (transmit_data_valid),
        .transmit_data_start      (transmit_data_start),
        .transmit_data_last       (transmit_data_last),
        .transmit_data_ready      (transmit_data_ready),
        .buffer_level             (buffer_level),
        .frame_drop_count         (frame_drop_count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset && transmit_data_valid && transmit_data_ready)
            got.push_back({transmit_data_start, transmit_data_last, transmit_data});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_word(input logic [8:0] w);
        port_transmit_data       = w;
        port_transmit_data_valid = 1'b1;
        tick();
        port_transmit_data_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) send_word({i == 0, base + 8'(i)});
    endtask

    task automatic idle(input int n);
        port_transmit_data_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic note_drop();
`ifdef PORT_EGRESS_BUFFER_DROP_COUNT_EN
        exp_drop++;
`endif
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int k = 0;
        while (!transmit_data_valid && k < bound) begin
            tick();
            k++;
        end
        check(tag, 32'(transmit_data_valid), 32'd1);
    endtask

    task automatic drain_to(input string tag, input int n);
        int k = 0;
        transmit_data_ready = 1'b1;
        while (got.size() < n && k < 200) begin
            tick();
            k++;
        end
        check(tag, 32'(got.size()), 32'(n));
    endtask

    task automatic check_frame(input string tag, input logic [7:0] base, input int n,
                               input int off);
        for (int i = 0; i < n; i++) begin
            logic [9:0] e;
            e = {i == 0, i == n - 1, base + 8'(i)};
            if (off + i < got.size()) check(tag, 32'(got[off + i]), 32'(e));
            else                      check(tag, 32'h3FF, 32'(e));
        end
    endtask

    initial begin
        reset                    = 1'b1;
        port_transmit_data       = '0;
        port_transmit_data_valid = 1'b0;
        transmit_data_ready      = 1'b1;
        tick();
        tick();
        check("rst_data",  32'(transmit_data), 32'h0);
        check("rst_valid", 32'(transmit_data_valid), 32'h0);
        check("rst_start", 32'(transmit_data_start), 32'h0);
        check("rst_last",  32'(transmit_data_last), 32'h0);
        check("rst_level", 32'(buffer_level), 32'h0);
        check("rst_drop",  32'(frame_drop_count), 32'h0);
        reset = 1'b0;
        tick();

        // 13-word frame closed by the idle gap
        send_word(9'h1AA);
        for (int i = 1; i <= 12; i++) send_word(9'(i));
        check("t1_level", 32'(buffer_level), 32'd13);
        idle(15);
        check("t1_no_out_at_commit", 32'(transmit_data_valid), 32'd0);
        tick();
        check("t1_valid_rise", 32'(transmit_data_valid), 32'd1);
        for (int i = 0; i < 13; i++) begin
            logic [7:0] eb;
            eb = (i == 0) ? 8'hAA : 8'(i);
            check("t1_valid", 32'(transmit_data_valid), 32'd1);
            check("t1_data",  32'(transmit_data), 32'(eb));
            check("t1_start", 32'(transmit_data_start), 32'(i == 0));
            check("t1_last",  32'(transmit_data_last), 32'(i == 12));
            tick();
        end
        check("t1_done_valid", 32'(transmit_data_valid), 32'd0);
        check("t1_done_level", 32'(buffer_level), 32'd0);
        got.delete();

        // Two 12-word frames back to back
        send_frame(8'hB0, 12);
        send_frame(8'hC0, 12);
        idle(15);
        drain_to("t2_count", 24);
        check_frame("t2_frame_a", 8'hB0, 12, 0);
        check_frame("t2_frame_b", 8'hC0, 12, 12);
        tick();
        check("t2_level", 32'(buffer_level), 32'd0);
        check("t2_drop",  32'(frame_drop_count), 32'd0);
        got.delete();

        // 5-word runt
        send_frame(8'hD0, 5);
        check("t3_level_written", 32'(buffer_level), 32'd5);
        idle(14);
        check("t3_level_before_close", 32'(buffer_level), 32'd5);
        idle(1);
        note_drop();
        check("t3_level_after", 32'(buffer_level), 32'd0);
        check("t3_drop", 32'(frame_drop_count), 32'(exp_drop));
        idle(3);
        check("t3_no_out", 32'(transmit_data_valid), 32'd0);
        check("t3_no_bytes", 32'(got.size()), 32'd0);

        // Oversized frame with the transmitter stalled
        transmit_data_ready = 1'b0;
        send_frame(8'hE0, 16);
        check("t4_full_level", 32'(buffer_level), 32'd16);
        send_word(9'h0F0);
        note_drop();
        check("t4_rewound", 32'(buffer_level), 32'd0);
        check("t4_drop", 32'(frame_drop_count), 32'(exp_drop));
        send_word(9'h0F1);
        send_word(9'h0F2);
        send_word(9'h0F3);
        check("t4_discard_level", 32'(buffer_level), 32'd0);
        idle(15);
        transmit_data_ready = 1'b1;
        idle(3);
        check("t4_no_out", 32'(transmit_data_valid), 32'd0);
        check("t4_level_end", 32'(buffer_level), 32'd0);

        // Output stalls
        transmit_data_ready = 1'b0;
        send_frame(8'hF0, 12);
        idle(15);
        wait_valid("t5_valid_timeout", 4);
        tick();
        check("t5_hold_start_data", 32'(transmit_data), 32'hF0);
        check("t5_hold_start_flag", 32'(transmit_data_start), 32'd1);
        transmit_data_ready = 1'b1;
        repeat (3) tick();
        transmit_data_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("t5_hold_valid", 32'(transmit_data_valid), 32'd1);
            check("t5_hold_data",  32'(transmit_data), 32'hF3);
            check("t5_hold_start", 32'(transmit_data_start), 32'd0);
            check("t5_hold_last",  32'(transmit_data_last), 32'd0);
        end
        drain_to("t5_mid_count", 11);
        transmit_data_ready = 1'b0;
        tick();
        check("t5_hold_last_data", 32'(transmit_data), 32'hFB);
        check("t5_hold_last_flag", 32'(transmit_data_last), 32'd1);
        drain_to("t5_count", 12);
        check_frame("t5_frame", 8'hF0, 12, 0);
        tick();
        check("t5_after_valid", 32'(transmit_data_valid), 32'd0);
        got.delete();

        // Reset in the middle of output
        send_frame(8'hA0, 12);
        idle(15);
        wait_valid("t6_valid_timeout", 4);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        exp_drop = 0;
        check("t6_rst_valid", 32'(transmit_data_valid), 32'd0);
        check("t6_rst_data",  32'(transmit_data), 32'd0);
        check("t6_rst_start", 32'(transmit_data_start), 32'd0);
        check("t6_rst_last",  32'(transmit_data_last), 32'd0);
        check("t6_rst_level", 32'(buffer_level), 32'd0);
        check("t6_rst_drop",  32'(frame_drop_count), 32'd0);
        tick();
        reset = 1'b0;
        got.delete();
        tick();
        send_frame(8'h50, 12);
        idle(15);
        drain_to("t6_count", 12);
        check_frame("t6_frame", 8'h50, 12, 0);
        tick();
        check("t6_level_end", 32'(buffer_level), 32'd0);
        check("t6_drop_end", 32'(frame_drop_count), 32'(exp_drop));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/port_egress_buffer.md
# port_egress_buffer

Per-port store-and-forward egress buffer on the switch transmit path. Accepts the 9-bit word stream (bit 8 = start-of-frame) the core orchestrator drives, with no backpressure, for one port. Commits only complete frames and replays them as a byte stream with valid/ready, start and last flags to the port transmitter. One instance per port.

## Interface
- DEPTH, 64: buffer entries; power of two, 16..256.
- GAP_LIMIT, 16'h000F: idle cycles (no input valid) that close an open frame.
- MIN_FRAME_WORDS, 12: frames shorter than this are dropped at close.

- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- port_transmit_data  input  9  word from orchestrator; bit 8 = start-of-frame, [7:0] = byte.
- port_transmit_data_valid  input  1  word valid this cycle; no backpressure exists.
- transmit_data  output  8  byte to port transmitter.
- transmit_data_valid  output  1  transmit_data holds a byte.
- transmit_data_start  output  1  byte is first of a frame.
- transmit_data_last  output  1  byte is last of a frame.
- transmit_data_ready  input  1  transmitter accepts the byte.
- buffer_level  output  $clog2(DEPTH)+1  occupied entries, including uncommitted.
- frame_drop_count  output  16  dropped frames, saturating.

## Operation
- Storage: DEPTH x 9-bit array, combinational read. Pointers write_pointer, commit_pointer, read_pointer, each $clog2(DEPTH)+1 bits, wrap modulo 2*DEPTH. Occupancy = write_pointer - read_pointer; full when occupancy == DEPTH.
- Write FSM:
  - W_IDLE: valid word with bit 8 = 1 is written, enter W_FRAME; bit 8 = 0 words discarded.
  - W_FRAME: valid words written, gap counter cleared. Frame closes on (a) gap counter reaching GAP_LIMIT or (b) valid word with bit 8 = 1. On close: length >= MIN_FRAME_WORDS sets commit_pointer = write_pointer, else write_pointer rewinds to commit_pointer and the drop counter increments. In case (b) the start word begins a new frame the same cycle, written at the post-close write position; stay in W_FRAME.
  - W_DISCARD: entered when a valid word arrives while full; write_pointer rewinds to commit_pointer, drop counter increments. Words ignored until a start word (W_FRAME, written if not full) or GAP_LIMIT idle cycles (W_IDLE).
- Start word arriving while full in W_IDLE: counts one drop, enters W_DISCARD.
- Read side: output register loads mem[read_pointer] when read_pointer != commit_pointer and the register is empty or being consumed the same cycle; read_pointer increments on load. start = stored bit 8; last = (read_pointer+1 == commit_pointer) or mem[read_pointer+1][8] with read_pointer+1 != write_pointer.
- Handshake: byte transfers when valid && ready. While valid && !ready, data, start, last stay stable. Back-to-back transfers at one byte per cycle.
- frame_drop_count saturates at 16'hFFFF.

## Timing
- Reset: transmit_data 0, transmit_data_valid 0, transmit_data_start 0, transmit_data_last 0, buffer_level 0, frame_drop_count 0; all pointers 0; write FSM W_IDLE; gap counter 0. Partial and committed frames lost.
- Write latency: word valid in cycle C is in memory and buffer_level after the edge ending C.
- Commit-to-output: close evaluated in cycle C; commit_pointer updates at end of C; transmit_data_valid rises at end of C+1 when the register was empty.
- Gap close: last data word at cycle C; frame commits at the edge ending cycle C+GAP_LIMIT.
- Simultaneous load and write in the same cycle are independent. A load in the same cycle as a full condition frees the entry only after the edge.

## Configuration
- PORT_EGRESS_BUFFER_DROP_COUNT_EN: when defined, frame_drop_count operates as above. When undefined, the counter is not built and frame_drop_count is tied to 16'h0000. Drop behaviour is otherwise identical.

## Test plan
- 13-word frame (start 0x1AA, then 0x001..0x00C), ready=1, then idle -> nothing output until GAP_LIMIT idle cycles pass; then 13 bytes AA,01..0C on consecutive cycles, start on AA, last on 0C.
- Two 12-word frames back-to-back (second start word directly after the first frame) -> first commits on the second start; output start/last boundaries are correct; frame_drop_count stays 0.
- 5-word runt followed by gap -> no output; buffer_level returns to 0; frame_drop_count = 1 (0 with macro undefined).
- DEPTH=16, ready=0, 20-word frame -> frame dropped on the 17th word; W_DISCARD until gap; buffer_level 0; count = 1.
- Output stall: ready toggled 1,0,0,1 mid-frame -> data, start and last held while stalled; no byte lost or duplicated.
- Reset asserted mid-output -> all outputs 0 immediately; after release a new 12-word frame is output intact.
